// File: rtl/dc_rep_download.sv
// dc_rep_download: reassembles the 16-bit reply flit stream into a message of
// up to MAX_FLITS flits. The finished message is held for the consumer, and
// no new flits are accepted while it is held, which stalls the upstream fifo.
//
// Ports:
//   clk, rst               clock (rising edge), synchronous active-high reset
//   flit_in, v_flit_in     flit from the rep fifo and its valid
//   ctrl_in                flit tag: 01 head, 10 body, 11 tail/single, 00 invalid
//   msg_taken              consumer pops the held message
//   flit_rdy               a flit can be accepted this cycle (decoded from state)
//   dc_flits_out           assembled message, flit 0 in the most significant slot
//   v_dc_flits_out         dc_flits_out holds a complete message
//   flits_num_out          flits in the message minus one
//   dc_rep_download_state  high while collecting or holding
//   err_proto              one-cycle pulse on a protocol violation
module dc_rep_download #(
   parameter int unsigned FLIT_W    = 16,
   parameter int unsigned MAX_FLITS = 11
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [FLIT_W-1:0]             flit_in,
   input  logic                          v_flit_in,
   input  logic [1:0]                    ctrl_in,
   input  logic                          msg_taken,
   output logic                          flit_rdy,
   output logic [FLIT_W*MAX_FLITS-1:0]   dc_flits_out,
   output logic                          v_dc_flits_out,
   output logic [3:0]                    flits_num_out,
   output logic                          dc_rep_download_state,
   output logic                          err_proto
);

   localparam int unsigned MSG_W = FLIT_W * MAX_FLITS;
   localparam int unsigned IDX_W = 4;

   localparam logic [1:0] CTRL_INV  = 2'b00;
   localparam logic [1:0] CTRL_HEAD = 2'b01;
   localparam logic [1:0] CTRL_BODY = 2'b10;
   localparam logic [1:0] CTRL_TAIL = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_FULL = 2'd2
   } state_t;

   state_t             r_state;
   logic [IDX_W-1:0]   r_idx;
   logic [MSG_W-1:0]   r_buf;
   logic [3:0]         r_num;
   logic               r_valid;
   logic               r_active;
   logic               r_err;

   state_t             w_state_nxt;
   logic [IDX_W-1:0]   w_idx_nxt;
   logic [3:0]         w_num_nxt;
   logic               w_err_nxt;
   logic               w_clr;
   logic               w_wr_en;
   logic [IDX_W-1:0]   w_wr_slot;
   logic               w_accept;
   logic               w_overflow;

   // Acceptance depends only on the registered state, never on msg_taken.
   assign w_accept   = v_flit_in && (r_state != ST_FULL);
   assign w_overflow = (r_idx >= IDX_W'(MAX_FLITS));

   // Next-state, slot write and error decode.
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_num_nxt   = r_num;
      w_err_nxt   = 1'b0;
      w_clr       = 1'b0;
      w_wr_en     = 1'b0;
      w_wr_slot   = r_idx;

      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               case (ctrl_in)
                  CTRL_HEAD: begin
                     w_clr       = 1'b1;
                     w_wr_en     = 1'b1;
                     w_wr_slot   = '0;
                     w_idx_nxt   = IDX_W'(1);
                     w_state_nxt = ST_BUSY;
                  end
                  CTRL_TAIL: begin
                     w_clr       = 1'b1;
                     w_wr_en     = 1'b1;
                     w_wr_slot   = '0;
                     w_idx_nxt   = '0;
                     w_num_nxt   = '0;
                     w_state_nxt = ST_FULL;
                  end
                  default: w_err_nxt = 1'b1;
               endcase
            end
         end

         ST_BUSY: begin
            if (w_accept) begin
               case (ctrl_in)
                  CTRL_BODY: begin
                     if (w_overflow) begin
                        w_err_nxt = 1'b1;
                     end else begin
                        w_wr_en   = 1'b1;
                        w_idx_nxt = r_idx + IDX_W'(1);
                     end
                  end
                  CTRL_TAIL: begin
                     // An overflowing tail still closes the message.
                     if (w_overflow) begin
                        w_err_nxt = 1'b1;
                        w_num_nxt = 4'(MAX_FLITS - 1);
                     end else begin
                        w_wr_en   = 1'b1;
                        w_num_nxt = 4'(r_idx);
                     end
                     w_idx_nxt   = '0;
                     w_state_nxt = ST_FULL;
                  end
                  CTRL_HEAD: begin
                     // Unexpected head: drop the partial message and restart.
                     w_err_nxt = 1'b1;
                     w_clr     = 1'b1;
                     w_wr_en   = 1'b1;
                     w_wr_slot = '0;
                     w_idx_nxt = IDX_W'(1);
                  end
                  CTRL_INV: w_err_nxt = 1'b1;
                  default:  w_err_nxt = 1'b1;
               endcase
            end
         end

         ST_FULL: begin
            if (msg_taken) begin
               w_state_nxt = ST_IDLE;
            end
         end

         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State, message buffer and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_idx    <= '0;
         r_buf    <= '0;
         r_num    <= '0;
         r_valid  <= 1'b0;
         r_active <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_idx    <= w_idx_nxt;
         r_num    <= w_num_nxt;
         r_valid  <= (w_state_nxt == ST_FULL);
         r_active <= (w_state_nxt != ST_IDLE);
         r_err    <= w_err_nxt;
         for (int k = 0; k < int'(MAX_FLITS); k++) begin
            if (w_clr) begin
               r_buf[MSG_W-1-FLIT_W*k -: FLIT_W] <= '0;
            end
            if (w_wr_en && (w_wr_slot == IDX_W'(k))) begin
               r_buf[MSG_W-1-FLIT_W*k -: FLIT_W] <= flit_in;
            end
         end
      end
   end

   assign flit_rdy              = (r_state != ST_FULL);
   assign dc_flits_out          = r_buf;
   assign v_dc_flits_out        = r_valid;
   assign flits_num_out         = r_num;
   assign dc_rep_download_state = r_active;
   assign err_proto             = r_err;

endmodule
